// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// master drives start/sub/a/b; slave returns busy/done/sum/cout/ovf.
interface serial_add_sub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial add/sub: one full-adder cell, LSB first, WIDTH steps.
// Ports: clk, rst (async high), bus (slave: start/sub/a/b -> busy/done/sum/cout/ovf).
module serial_add_sub #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   serial_add_sub_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             s_bit;
   logic             c_next;
   logic             load;

   always_comb begin
      s_bit   = a_q[0] ^ b_q[0] ^ carry_q;
      c_next  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      work_d  = work_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      load    = 1'b0;

      unique case (state_q)
         S_IDLE: load = bus.start;
         S_RUN: begin
            work_d  = {s_bit, work_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = c_next;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               // carry_q here is the MSB carry-in
               state_d = S_DONE;
               sum_d   = {s_bit, work_q[WIDTH-1:1]};
               cout_d  = c_next;
               ovf_d   = carry_q ^ c_next;
               done_d  = 1'b1;
            end else begin
               busy_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            load    = bus.start;
         end
         default: state_d = S_IDLE;
      endcase

      // Subtraction is a + ~b + 1: invert B, seed carry with 1
      if (load) begin
         a_d     = bus.a;
         b_d     = bus.b ^ {WIDTH{bus.sub}};
         carry_d = bus.sub;
         cnt_d   = '0;
         state_d = S_RUN;
         busy_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         work_q  <= work_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Testbench for serial_add_sub: vector table, handshake sequences,
// random WIDTH=8 and exhaustive WIDTH=4 against an arithmetic model.
module tb_serial_add_sub;
   logic clk = 1'b0;
   logic rst = 1'b1;

   serial_add_sub_if #(.WIDTH(8)) bus8 ();
   serial_add_sub_if #(.WIDTH(4)) bus4 ();

   serial_add_sub #(.WIDTH(8)) u8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   serial_add_sub #(.WIDTH(4)) u4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int bd_viol = 0;

   always @(negedge clk) begin
      if ((bus8.busy && bus8.done) || (bus4.busy && bus4.done))
         bd_viol++;
   end

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Plain integer arithmetic on the unsigned/signed readings.
   function automatic void model(input int w,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic s,
                                 output logic [31:0] es,
                                 output logic ec,
                                 output logic ev);
      longint p2, ua, ub, sa, sb, r, sr;
      p2 = longint'(1) << w;
      ua = longint'({32'b0, a}) & (p2 - 1);
      ub = longint'({32'b0, b}) & (p2 - 1);
      sa = (ua >= p2 / 2) ? ua - p2 : ua;
      sb = (ub >= p2 / 2) ? ub - p2 : ub;
      r  = s ? ua - ub : ua + ub;
      sr = s ? sa - sb : sa + sb;
      es = 32'(r & (p2 - 1));
      ec = s ? (ua >= ub) : (r >= p2);
      ev = (sr >= p2 / 2) || (sr < -(p2 / 2));
   endfunction

   task automatic wait_done(input bit w4, output int lat);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (w4 ? bus4.done : bus8.done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic do_op(input bit w4,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic s,
                        output logic [31:0] rs,
                        output logic rc,
                        output logic rv,
                        output int lat);
      @(negedge clk);
      if (w4) begin
         bus4.start = 1'b1; bus4.a = a[3:0];
         bus4.b = b[3:0]; bus4.sub = s;
      end else begin
         bus8.start = 1'b1; bus8.a = a[7:0];
         bus8.b = b[7:0]; bus8.sub = s;
      end
      @(posedge clk);
      #1;
      bus4.start = 1'b0;
      bus8.start = 1'b0;
      wait_done(w4, lat);
      rs = w4 ? 32'(bus4.sum) : 32'(bus8.sum);
      rc = w4 ? bus4.cout : bus8.cout;
      rv = w4 ? bus4.ovf : bus8.ovf;
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       s;
      logic [7:0] es;
      logic       ec;
      logic       ev;
   } vec_t;

   vec_t vt[5];

   initial begin
      logic [31:0] rs, es, prev;
      logic        rc, rv, ec, ev;
      int          lat, chg, dcnt;
      logic [7:0]  ra, rb;
      logic        rsub;

      vt[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
      vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[2] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
      vt[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
      vt[4] = '{8'h37, 8'h37, 1'b1, 8'h00, 1'b1, 1'b0};

      bus8.start = 0; bus8.sub = 0; bus8.a = 0; bus8.b = 0;
      bus4.start = 0; bus4.sub = 0; bus4.a = 0; bus4.b = 0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", bus8.busy, 0);
      check("rst_done", bus8.done, 0);
      check("rst_sum", bus8.sum, 0);
      check("rst_cout", bus8.cout, 0);
      check("rst_ovf", bus8.ovf, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vt[i]) begin
         do_op(0, vt[i].a, vt[i].b, vt[i].s, rs, rc, rv, lat);
         check($sformatf("vec%0d_lat", i), lat, 8);
         check($sformatf("vec%0d_sum", i), rs, vt[i].es);
         check($sformatf("vec%0d_cout", i), rc, vt[i].ec);
         check($sformatf("vec%0d_ovf", i), rv, vt[i].ev);
      end

      // Hold start through RUN while scrambling the operands
      prev = 32'(bus8.sum);
      chg = 0;
      @(negedge clk);
      bus8.start = 1; bus8.a = 8'h5A; bus8.b = 8'h33; bus8.sub = 0;
      @(posedge clk);
      #1;
      check("hold_busy_e0", bus8.busy, 1);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         bus8.a = 8'($urandom);
         bus8.b = 8'($urandom);
         bus8.sub = 1'($urandom);
         @(posedge clk);
         #1;
         if (bus8.done) begin
            lat = k;
            break;
         end
         if (32'(bus8.sum) != prev) chg++;
      end
      bus8.start = 0;
      check("hold_lat", lat, 8);
      check("hold_sum_stable", chg, 0);
      check("hold_sum", bus8.sum, 8'h8D);
      check("hold_cout", bus8.cout, 0);
      check("hold_ovf", bus8.ovf, 1);
      check("hold_idle_busy", bus8.busy, 0);

      // Back-to-back: start raised during the DONE cycle
      do_op(0, 32'h10, 32'h20, 1, rs, rc, rv, lat);
      check("b2b_first_sum", rs, 8'hF0);
      check("b2b_done_busy", bus8.busy, 0);
      bus8.start = 1; bus8.a = 8'h80; bus8.b = 8'h01; bus8.sub = 1;
      @(posedge clk);
      #1;
      bus8.start = 0;
      check("b2b_busy", bus8.busy, 1);
      check("b2b_done_low", bus8.done, 0);
      wait_done(0, lat);
      check("b2b_lat", lat, 8);
      check("b2b_sum", bus8.sum, 8'h7F);
      check("b2b_cout", bus8.cout, 1);
      check("b2b_ovf", bus8.ovf, 1);

      for (int i = 0; i < 150; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rsub = 1'($urandom);
         do_op(0, 32'(ra), 32'(rb), rsub, rs, rc, rv, lat);
         model(8, 32'(ra), 32'(rb), rsub, es, ec, ev);
         check($sformatf("rnd%0d_lat", i), lat, 8);
         check($sformatf("rnd%0d_%h%s%h", i, ra, rsub ? "-" : "+", rb),
               {rs[29:0], rc, rv}, {es[29:0], ec, ev});
      end

      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
               do_op(1, 32'(a), 32'(b), 1'(s), rs, rc, rv, lat);
               model(4, 32'(a), 32'(b), 1'(s), es, ec, ev);
               check($sformatf("w4_lat_%0d_%0d_%0d", s, a, b), lat, 4);
               check($sformatf("w4_%0d_%0d_%0d", s, a, b),
                     {rs[29:0], rc, rv}, {es[29:0], ec, ev});
            end

      // Asynchronous abort at E3 of 5A+33
      @(negedge clk);
      bus8.start = 1; bus8.a = 8'h5A; bus8.b = 8'h33; bus8.sub = 0;
      @(posedge clk);
      #1;
      bus8.start = 0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_busy", bus8.busy, 0);
      check("abort_done", bus8.done, 0);
      check("abort_sum", bus8.sum, 0);
      check("abort_cout", bus8.cout, 0);
      check("abort_ovf", bus8.ovf, 0);
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus8.done || bus8.busy) dcnt++;
      end
      check("abort_no_done", dcnt, 0);

      check("busy_done_exclusive", bd_viol, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop. It processes one operand bit per clock, LSB first, under a start/busy/done handshake. It is the area-minimal sequential arithmetic unit of the full-adder family, for control paths where WIDTH cycles of latency is acceptable in exchange for one adder cell.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a new operation; sampled on rising clk edge
- sub  in  1  0 = a + b, 1 = a - b; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  high while an operation is in progress
- done  out  1  single-cycle pulse; result valid
- sum  out  WIDTH  result, registered, held until the next completion
- cout  out  1  carry out of MSB; for subtraction, 1 = no borrow (a >= b unsigned)
- ovf  out  1  two's-complement overflow

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE:** when start=1, latch a into shift register A, and latch b XOR {WIDTH{sub}} into shift register B. Load carry := sub, clear bit counter := 0, and go to RUN. When start=0, stay in IDLE.
- **RUN:** every cycle one full-adder step runs on A[0], B[0] and carry.
  - The sum bit shifts into the MSB of the work register, which right-shifts. A and B right-shift.
  - carry := majority(A[0], B[0], carry). counter increments.
  - On the step where counter = WIDTH-1, record the carry into that step as the MSB carry-in. At the end of that step go to DONE and copy the work register to sum, the final carry to cout, and (MSB carry-in XOR final carry) to ovf.
- **DONE:** lasts exactly one cycle, then goes to IDLE. If start=1 in DONE, the block instead latches the new operands as in IDLE and goes to RUN directly (back-to-back operation).
- start is ignored in RUN. Changes on a, b and sub outside the accepting edge have no effect.
- sum, cout and ovf change only on entry to DONE. They keep their previous values while a new operation runs.
- Counter width is $clog2(WIDTH)+1. No state other than IDLE, RUN and DONE is reachable. Any illegal encoding returns to IDLE.

## Timing
- **Reset values:** busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE, internal registers 0.
- Reset asserted mid-operation aborts it immediately and asynchronously. No done pulse is produced, and the outputs return to their reset values.
- **Latency:**
  - The start edge is E0. busy=1 from E0 to E_WIDTH. At E_WIDTH, busy falls, done rises, and the result appears. At E_WIDTH+1, done falls.
  - Throughput is one result per WIDTH+1 cycles.
  - With back-to-back start in DONE, busy is low for exactly the one DONE cycle.
- busy and done are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Boundary cases:
  - a+b wraps modulo 2^WIDTH with cout=1.
  - a-b with a<b gives the two's-complement difference with cout=0.
  - A sub result of 0 gives cout=1.

## Test plan
- **Reset:** WIDTH=8, start 8'h5A+8'h33, assert rst at E3 -> busy, done, sum, cout and ovf all 0 immediately; no done pulse after rst releases.
- **Add with signed overflow:** WIDTH=8, sub=0, a=8'h5A, b=8'h33 -> done exactly 8 edges after the start edge; sum=8'h8D, cout=0, ovf=1.
- **Add with wrap:** a=8'hFF, b=8'h01, sub=0 -> sum=8'h00, cout=1, ovf=0.
- **Subtract:**
  - a=8'h10, b=8'h20 -> sum=8'hF0, cout=0, ovf=0.
  - a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
  - a=8'h37, b=8'h37 -> sum=8'h00, cout=1, ovf=0.
- **Handshake:**
  - Hold start=1 and toggle a, b and sub during RUN -> result equals the operands captured at E0; sum is unchanged until done.
  - start in the DONE cycle -> busy high again on the next edge; the second result is correct.
- **Exhaustive:** WIDTH=4, all a, b and sub (512 cases) -> sum, cout and ovf match a behavioural model. done occurs 4 edges after every start, and busy/done are never both high.
